instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the main/ALU control decode path: accepts symbolic instruction requests (kind, ALU op, registers, immediate) and encodes them into 32-bit RV32I machine words. Writes encoded words sequentially into instruction memory through a write port. Used by testbenches and the boot path to load programs that the single-cycle core then fetches and decodes.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
BASE_ADDR, 0, word address loaded into the write pointer on reset and on start.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  restart load: pointer=BASE_ADDR, count=0, abort in-flight request
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_kind  in  3  0 R-type, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JAL, 6-7 illegal
req_aluop  in  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5-7 illegal (used for kinds 0/1 only)
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  32  signed byte-offset/immediate
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
err  out  1  one-cycle pulse: illegal request dropped
count  out  ADDR_W+1  words written since reset/start
full  out  1  count == 2^ADDR_W

Behaviour:
- Reset values: req_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, err=0, count=0, full=0.
- FSM IDLE -> ENC -> WR -> IDLE. Handshake accepts on req_valid & req_ready. req_ready = (state==IDLE) & ~full & ~start.
- ENC: register the encoded word and the legality check. If illegal: err=1 for one cycle, no write, pointer/count unchanged, next state IDLE.
- WR: imem_we=1 for exactly one cycle with imem_addr=pointer and imem_wdata=word. On the next edge pointer+1 (wraps modulo 2^ADDR_W) and count+1.
- Latency: accept edge -> imem_we high 2 cycles later. Throughput: 1 request per 3 cycles.
- Encodings: R op 0110011, funct3 add/sub 000, and 111, or 110, slt 010, funct7 0100000 for sub else 0. I-ALU op 0010011, same funct3, sub illegal. LW op 0000011, funct3 010. SW op 0100011, funct3 010. BEQ op 1100011, funct3 000. JAL op 1101111. Immediate bit placement follows the standard I/S/B/J formats.
- Unused register fields are encoded as 0: rs2 for I/LW; rd for SW/BEQ; rs1 and rs2 for JAL.
- Illegal conditions:
  - kind 6-7.
  - aluop 5-7 for kinds 0/1.
  - I-ALU/LW/SW imm outside -2048..2047.
  - BEQ imm outside -4096..4094 or odd.
  - JAL imm outside -1048576..1048574 or odd.
- Full: req_ready=0 and no further writes until start or reset. The pointer does not advance past a full memory.
- start in any state: next state IDLE, pointer=BASE_ADDR, count=0. An in-flight request is discarded and produces no write. start has priority over a simultaneous req_valid; that request is not accepted.
- reset mid-operation: same as the reset values, with no write issued.

Optional Feature:
READBACK_CHECK_EN: adds input imem_rdata[31:0] (combinational read of imem_addr) and output mismatch (sticky, cleared by reset/start). Adds state VFY after WR, with pointer held. In VFY, imem_rdata != stored word sets mismatch and pulses err. The pointer advances when leaving VFY, so throughput is 1 per 4 cycles. Without the macro: no imem_rdata/mismatch ports, no VFY state.

Test Plan:
- Reset, then R add rd=3 rs1=1 rs2=2 -> imem_we at addr 0, wdata 0x002081B3, two cycles after accept; count=1.
- LW rd=5 rs1=0 imm=8, then SW rs1=0 rs2=6 imm=12 -> wdata 0x00802283 at addr 1, then 0x00602623 at addr 2.
- BEQ rs1=1 rs2=2 imm=-8 -> wdata 0xFE208CE3. BEQ imm=-7 -> err pulse, no write, count unchanged.
- I-ALU add imm=2048 and I-ALU sub -> err each, no imem_we. Next legal request is written at the unchanged address.
- ADDR_W=2: four legal writes -> full=1, req_ready=0, count=4. A fifth req_valid is not accepted. start -> count=0, imem_addr=BASE_ADDR, req_ready=1.
- start asserted in the cycle after accepting a request, and separately reset asserted in ENC -> no imem_we, state IDLE, count=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns symbolic instruction requests (kind, ALU op,
// registers, immediate) into RV32I machine words and writes them one by one
// into instruction memory starting at BASE_ADDR.
// Optional macro READBACK_CHECK_EN adds a verify cycle that compares the
// memory read-back with the written word (imem_rdata in, sticky mismatch out).
// Timing: if the request is accepted in cycle 0, ENC is cycle 1 and the
// write strobe (or the err pulse for an illegal request) is seen in cycle 2.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_aluop,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
`ifdef READBACK_CHECK_EN
  input  logic [31:0]       imem_rdata,
  output logic              mismatch,
`endif
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
`ifdef READBACK_CHECK_EN
  localparam logic [1:0] VFY  = 2'd3;
`endif

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       word;

  // request captured at the handshake, encoded during ENC
  logic [2:0]  r_kind, r_aluop;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [31:0] r_imm;

  logic signed [31:0] simm;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alu_ok, imm12_ok, legal;
  logic [31:0] enc_word;

  assign simm     = r_imm;
  assign full     = (cnt == CAP);
  assign req_ready = (state == IDLE) & ~full & ~start;
  // a request killed by start/reset in its write cycle must not reach memory
  assign imem_we  = (state == WR) & ~start & ~reset;
  assign imem_addr  = ptr;
  assign imem_wdata = word;
  assign busy     = (state != IDLE);
  assign count    = cnt;

  // field encoding and legality of the captured request
  always_comb begin
    f3       = 3'b000;
    f7       = 7'b0000000;
    alu_ok   = 1'b1;
    legal    = 1'b1;
    enc_word = 32'h0;
    case (r_aluop)
      3'd0: f3 = 3'b000;
      3'd1: begin f3 = 3'b000; f7 = 7'b0100000; end
      3'd2: f3 = 3'b111;
      3'd3: f3 = 3'b110;
      3'd4: f3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
    imm12_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    case (r_kind)
      3'd0: begin
        enc_word = {f7, r_rs2, r_rs1, f3, r_rd, 7'b0110011};
        legal    = alu_ok;
      end
      3'd1: begin
        enc_word = {r_imm[11:0], r_rs1, f3, r_rd, 7'b0010011};
        legal    = alu_ok && (r_aluop != 3'd1) && imm12_ok;
      end
      3'd2: begin
        enc_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, 7'b0000011};
        legal    = imm12_ok;
      end
      3'd3: begin
        enc_word = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], 7'b0100011};
        legal    = imm12_ok;
      end
      3'd4: begin
        enc_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b000,
                    r_imm[4:1], r_imm[11], 7'b1100011};
        legal    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !r_imm[0];
      end
      3'd5: begin
        enc_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12],
                    r_rd, 7'b1101111};
        legal    = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !r_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // load sequencer: accept, encode, write, advance pointer and count
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= BASE;
      cnt     <= '0;
      word    <= '0;
      err     <= 1'b0;
      r_kind  <= '0;
      r_aluop <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
`ifdef READBACK_CHECK_EN
      mismatch <= 1'b0;
`endif
    end else if (start) begin
      state <= IDLE;
      ptr   <= BASE;
      cnt   <= '0;
      err   <= 1'b0;
`ifdef READBACK_CHECK_EN
      mismatch <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          r_kind  <= req_kind;
          r_aluop <= req_aluop;
          r_rd    <= req_rd;
          r_rs1   <= req_rs1;
          r_rs2   <= req_rs2;
          r_imm   <= req_imm;
          state   <= ENC;
        end
        ENC: begin
          word <= enc_word;
          if (legal) state <= WR;
          else begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
`ifdef READBACK_CHECK_EN
        WR: state <= VFY;
        VFY: begin
          if (imem_rdata != word) begin
            mismatch <= 1'b1;
            err      <= 1'b1;
          end
          ptr   <= ptr + 1'b1;
          cnt   <= cnt + 1'b1;
          state <= IDLE;
        end
`else
        WR: begin
          ptr   <= ptr + 1'b1;
          cnt   <= cnt + 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed test-plan scenarios with literal
// expectations, then randomized requests/start/reset, all checked every cycle
// against a transaction-level model (cycles-since-accept plus an arithmetic
// RV32I encoder).
module tb_instr_encoder_loader;
  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  logic clk = 0, reset = 1, start = 0, req_valid = 0;
  logic req_ready;
  logic [2:0] req_kind = 0, req_aluop = 0;
  logic [4:0] req_rd = 0, req_rs1 = 0, req_rs2 = 0;
  logic [31:0] req_imm = 0;
  logic imem_we, busy, err, full;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid),
    .req_ready(req_ready), .req_kind(req_kind), .req_aluop(req_aluop),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .err(err), .count(count), .full(full));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, err_seen = 0;
  int log_addr[$], log_cyc[$];
  logic [31:0] log_data[$];

  // model state: age = cycles since accept (-1 idle)
  bit armed = 0;
  int age = -1, m_cnt = 0, m_ptr = 0;
  bit m_err = 0, m_ok = 0;
  logic [31:0] m_word = 0;

  int bnd[13] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, 1048575, -1048576, -1048578, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RV32I encoding straight from the instruction format tables
  task automatic model_encode(input int kind, input int aluop, input int rd,
                              input int rs1, input int rs2, input int imm,
                              output logic [31:0] w, output bit ok);
    logic [31:0] u, f3, f7, d, s1, s2;
    bit alu_ok;
    u = imm; d = rd; s1 = rs1; s2 = rs2;
    alu_ok = (aluop <= 4);
    f3 = (aluop == 2) ? 7 : (aluop == 3) ? 6 : (aluop == 4) ? 2 : 0;
    f7 = (aluop == 1) ? 32 : 0;
    w = 0; ok = 0;
    case (kind)
      0: begin w = f7 << 25 | s2 << 20 | s1 << 15 | f3 << 12 | d << 7 | 32'h33; ok = alu_ok; end
      1: begin
        w = (u & 32'hFFF) << 20 | s1 << 15 | f3 << 12 | d << 7 | 32'h13;
        ok = alu_ok && aluop != 1 && imm >= -2048 && imm <= 2047;
      end
      2: begin w = (u & 32'hFFF) << 20 | s1 << 15 | 2 << 12 | d << 7 | 32'h03; ok = imm >= -2048 && imm <= 2047; end
      3: begin
        w = ((u >> 5) & 32'h7F) << 25 | s2 << 20 | s1 << 15 | 2 << 12 | (u & 32'h1F) << 7 | 32'h23;
        ok = imm >= -2048 && imm <= 2047;
      end
      4: begin
        w = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3F) << 25 | s2 << 20 | s1 << 15 |
            ((u >> 1) & 32'hF) << 8 | ((u >> 11) & 1) << 7 | 32'h63;
        ok = imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
      end
      5: begin
        w = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3FF) << 21 | ((u >> 11) & 1) << 20 |
            ((u >> 12) & 32'hFF) << 12 | d << 7 | 32'h6F;
        ok = imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
      end
      default: ok = 0;
    endcase
  endtask

  // model update on each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      armed = 1; age = -1; m_cnt = 0; m_ptr = 0; m_err = 0;
    end else if (start) begin
      age = -1; m_cnt = 0; m_ptr = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (age == 1) begin
        if (m_ok) age = 2;
        else begin age = -1; m_err = 1; end
      end else if (age == 2) begin
        m_cnt++; m_ptr = (m_ptr + 1) % CAP; age = -1;
      end else if (req_valid && m_cnt != CAP) begin
        model_encode(req_kind, req_aluop, req_rd, req_rs1, req_rs2, req_imm, m_word, m_ok);
        age = 1;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("req_ready", req_ready, age < 0 && m_cnt != CAP && !start);
      chk("busy", busy, age >= 0);
      chk("err", err, m_err);
      chk("count", count, m_cnt);
      chk("full", full, m_cnt == CAP);
      chk("imem_addr", imem_addr, m_ptr);
      chk("imem_we", imem_we, age == 2 && !start && !reset);
      if (imem_we && age == 2) chk("imem_wdata", imem_wdata, m_word);
      if (imem_we) begin
        log_addr.push_back(imem_addr); log_data.push_back(imem_wdata); log_cyc.push_back(cyc);
      end
      if (err) err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k, input int al, input int rd, input int rs1,
                      input int rs2, input int imm);
    bit done = 0;
    req_valid = 1; req_kind = k; req_aluop = al; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin done = 1; acc_cyc = cyc; end
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic pin(input string nm, input int k, input int al, input int rd,
                     input int rs1, input int rs2, input int imm,
                     input logic [31:0] expw, input bit expok);
    logic [31:0] w; bit ok;
    model_encode(k, al, rd, rs1, rs2, imm, w, ok);
    chk({nm, "_ok"}, ok, expok);
    if (expok) chk({nm, "_word"}, w, expw);
  endtask

  initial begin
    int n0, e0, r, imm;
    // hand-computed encodings that pin the model
    pin("pin_add", 0, 0, 3, 1, 2, 0, 32'h002081B3, 1);
    pin("pin_sub", 0, 1, 3, 1, 2, 0, 32'h402081B3, 1);
    pin("pin_lw", 2, 0, 5, 0, 0, 8, 32'h00802283, 1);
    pin("pin_sw", 3, 0, 0, 0, 6, 12, 32'h00602623, 1);
    pin("pin_beq", 4, 0, 0, 1, 2, -8, 32'hFE208CE3, 1);
    pin("pin_jal", 5, 0, 1, 0, 0, 8, 32'h008000EF, 1);
    pin("pin_jalmin", 5, 0, 0, 0, 0, -1048576, 32'h8000006F, 1);
    pin("pin_addi_m1", 1, 0, 1, 1, 0, -1, 32'hFFF08093, 1);
    pin("pin_beq_odd", 4, 0, 0, 1, 2, -7, 0, 0);
    pin("pin_addi_big", 1, 0, 1, 1, 0, 2048, 0, 0);

    tick(2); reset = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1); chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0); chk("rst_count", count, 0);
    tick(1);

    send(0, 0, 3, 1, 2, 0); tick(3);
    chk("add_addr", log_addr[$], 0); chk("add_data", log_data[$], 32'h002081B3);
    chk("add_latency", log_cyc[$] - acc_cyc, 2); chk("add_count", count, 1);

    send(2, 0, 5, 0, 0, 8); tick(3);
    chk("lw_addr", log_addr[$], 1); chk("lw_data", log_data[$], 32'h00802283);
    send(3, 0, 0, 0, 6, 12); tick(3);
    chk("sw_addr", log_addr[$], 2); chk("sw_data", log_data[$], 32'h00602623);
    send(4, 0, 0, 1, 2, -8); tick(3);
    chk("beq_addr", log_addr[$], 3); chk("beq_data", log_data[$], 32'hFE208CE3);

    n0 = log_addr.size(); e0 = err_seen;
    send(4, 0, 0, 1, 2, -7); tick(3);
    chk("beq_odd_err", err_seen - e0, 1); chk("beq_odd_nowr", log_addr.size() - n0, 0);
    chk("beq_odd_count", count, 4);
    send(1, 0, 1, 1, 0, 2048); tick(3);
    send(1, 1, 1, 1, 0, 5); tick(3);
    chk("ialu_err", err_seen - e0, 3); chk("ialu_nowr", log_addr.size() - n0, 0);
    send(1, 0, 1, 1, 0, -1); tick(3);
    chk("addi_addr", log_addr[$], 4); chk("addi_data", log_data[$], 32'hFFF08093);

    // fill to capacity
    for (int i = 0; i < 3; i++) begin send(5, 0, 1, 0, 0, 8); tick(3); end
    @(negedge clk);
    chk("full_flag", full, 1); chk("full_ready", req_ready, 0); chk("full_count", count, CAP);
    tick(1);
    n0 = log_addr.size();
    req_valid = 1; tick(6); req_valid = 0;
    chk("full_noacc", log_addr.size() - n0, 0); chk("full_count2", count, CAP);
    start = 1; tick(1); start = 0;
    @(negedge clk);
    chk("start_count", count, 0); chk("start_addr", imem_addr, 0); chk("start_ready", req_ready, 1);
    tick(1);

    // abort in ENC by start, then by reset
    n0 = log_addr.size();
    send(0, 2, 4, 5, 6, 0); start = 1; tick(1); start = 0; tick(3);
    chk("abort_start_nowr", log_addr.size() - n0, 0); chk("abort_start_busy", busy, 0);
    chk("abort_start_count", count, 0);
    send(0, 3, 4, 5, 6, 0); reset = 1; tick(1); reset = 0; tick(3);
    chk("abort_reset_nowr", log_addr.size() - n0, 0); chk("abort_reset_busy", busy, 0);
    chk("abort_reset_count", count, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      req_kind = (r < 14) ? r % 6 : 6 + r % 2;
      req_aluop = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) req_aluop = req_aluop % 5;
      req_rd = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
      case ($urandom_range(0, 3))
        0: imm = int'($urandom_range(0, 4095)) - 2048;
        1: imm = $urandom;
        2: imm = bnd[$urandom_range(0, 12)];
        default: imm = int'($urandom_range(0, 8191)) - 4096;
      endcase
      req_imm = imm;
      start = ($urandom_range(0, 59) == 0) || (m_cnt == CAP && $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    start = 0; reset = 0; req_valid = 0; tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
